riscv_multicycle_core: RTL

//  Parametrised multi-cycle RV32I-subset core: fetch/decode/read/execute/writeback FSM, register file and ALU in one block.

---
 rtl/riscv_multicycle_core.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I-subset core: IDLE/FETCH/DECODE/READ/EXEC/WB/HALT FSM, register file and ALU.
// Optional BEQ/BNE support is compiled in with `define BRANCH_EN.
module riscv_multicycle_core #(
    parameter int XLEN    = 32,
    parameter int PC_W    = 10,
    parameter int NREGS   = 32,
    parameter int DBG_REG = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn,
    input  logic            run_mode,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_data,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      state,
    output logic [XLEN-1:0] alu_result,
    output logic            result_ready,
    output logic            inst_retired,
    output logic            halted,
    output logic            illegal,
    output logic [XLEN-1:0] dbg_reg
);
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int SH = $clog2(XLEN);
    localparam logic [RW-1:0] DBG_IDX = RW'(DBG_REG);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_READ = 3'd3,
        S_EXEC = 3'd4, S_WB = 3'd5, S_HALT = 3'd6
    } state_t;

    state_t          st;
    logic [31:0]     ir;
    logic [XLEN-1:0] rf [NREGS];
    logic [XLEN-1:0] op_a, op_b, alu_out, imm;
    logic [2:0]      alu_op;
    logic            use_imm, wr_q, btn_q;
    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic [4:0]      rd_f, rs1_f, rs2_f;
    logic            d_legal, d_ecall, d_imm, d_wr;
    logic [2:0]      d_alu;
    logic [PC_W-1:0] pc_next;
`ifdef BRANCH_EN
    logic            d_br, br_q, br_ne_q;
    logic [12:0]     bimm;
    logic [31:0]     boff32;
    logic [PC_W-1:0] br_off;
`endif

    assign state     = st;
    assign imem_addr = pc;
    assign dbg_reg   = rf[DBG_IDX];

    assign opcode = ir[6:0];
    assign rd_f   = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1_f  = ir[19:15];
    assign rs2_f  = ir[24:20];
    assign f7     = ir[31:25];
    assign imm    = {{(XLEN-12){ir[31]}}, ir[31:20]};

    function automatic logic reg_ok(input logic [4:0] idx);
        return (32'(idx) >> RW) == 32'd0;
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] fn);
        case (fn)
            3'b000:  return 3'd0;
            3'b001:  return 3'd2;
            3'b100:  return 3'd4;
            3'b101:  return 3'd5;
            3'b110:  return 3'd6;
            3'b111:  return 3'd7;
            default: return 3'd3;
        endcase
    endfunction

    always_comb begin
        d_ecall = (ir == 32'h0000_0073);
        d_legal = 1'b0;
        d_alu   = alu_of(f3);
        d_imm   = 1'b0;
        d_wr    = 1'b0;
`ifdef BRANCH_EN
        d_br    = 1'b0;
`endif
        case (opcode)
            7'b0110011: begin
                d_wr    = 1'b1;
                d_legal = (f3 != 3'b011) && (f7 == 7'd0 || (f7 == 7'b0100000 && f3 == 3'b000))
                          && reg_ok(rs1_f) && reg_ok(rs2_f) && reg_ok(rd_f);
                if (f3 == 3'b000 && f7[5]) d_alu = 3'd1;
            end
            7'b0010011: begin
                d_wr    = 1'b1;
                d_imm   = 1'b1;
                d_legal = (f3 != 3'b001) && (f3 != 3'b011) && (f3 != 3'b101)
                          && reg_ok(rs1_f) && reg_ok(rd_f);
            end
`ifdef BRANCH_EN
            7'b1100011: begin
                d_br    = 1'b1;
                d_alu   = 3'd1;
                d_legal = (f3[2:1] == 2'b00) && !ir[8] && reg_ok(rs1_f) && reg_ok(rs2_f);
            end
`endif
            default: d_legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_out = '0;
        case (alu_op)
            3'd0: alu_out = op_a + op_b;
            3'd1: alu_out = op_a - op_b;
            3'd2: alu_out = op_a << op_b[SH-1:0];
            3'd3: alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            3'd4: alu_out = op_a ^ op_b;
            3'd5: alu_out = op_a >> op_b[SH-1:0];
            3'd6: alu_out = op_a | op_b;
            3'd7: alu_out = op_a & op_b;
            default: alu_out = '0;
        endcase
    end

`ifdef BRANCH_EN
    // B-immediate is a byte offset; drop the two low bits to get a word offset
    assign bimm   = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign boff32 = {{21{bimm[12]}}, bimm[12:2]};
    always_comb begin
        pc_next = pc + PC_W'(1);
        if (br_q && ((alu_result == '0) != br_ne_q)) pc_next = pc + br_off;
    end
`else
    assign pc_next = pc + PC_W'(1);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st           <= S_IDLE;
            pc           <= '0;
            ir           <= '0;
            op_a         <= '0;
            op_b         <= '0;
            alu_op       <= '0;
            use_imm      <= 1'b0;
            wr_q         <= 1'b0;
            btn_q        <= 1'b0;
            imem_req     <= 1'b0;
            alu_result   <= '0;
            result_ready <= 1'b0;
            inst_retired <= 1'b0;
            halted       <= 1'b0;
            illegal      <= 1'b0;
`ifdef BRANCH_EN
            br_q         <= 1'b0;
            br_ne_q      <= 1'b0;
            br_off       <= '0;
`endif
            for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            btn_q        <= btn;
            result_ready <= 1'b0;
            inst_retired <= 1'b0;
            case (st)
                S_IDLE: if (run_mode || (btn && !btn_q)) begin
                    st       <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: if (imem_ready) begin
                    ir       <= imem_data;
                    imem_req <= 1'b0;
                    st       <= S_DECODE;
                end
                S_DECODE: begin
                    if (d_ecall) begin
                        st     <= S_HALT;
                        halted <= 1'b1;
                    end else if (!d_legal) begin
                        st      <= S_HALT;
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                    end else begin
                        st      <= S_READ;
                        alu_op  <= d_alu;
                        use_imm <= d_imm;
                        wr_q    <= d_wr && (rd_f != 5'd0);
`ifdef BRANCH_EN
                        br_q    <= d_br;
                        br_ne_q <= f3[0];
                        br_off  <= boff32[PC_W-1:0];
`endif
                    end
                end
                S_READ: begin
                    op_a <= rf[rs1_f[RW-1:0]];
                    op_b <= use_imm ? imm : rf[rs2_f[RW-1:0]];
                    st   <= S_EXEC;
                end
                S_EXEC: begin
                    alu_result   <= alu_out;
                    result_ready <= 1'b1;
                    inst_retired <= 1'b1;
                    st           <= S_WB;
                end
                S_WB: begin
                    if (wr_q) rf[rd_f[RW-1:0]] <= alu_result;
                    pc <= pc_next;
                    if (run_mode) begin
                        st       <= S_FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        st <= S_IDLE;
                    end
                end
                S_HALT:  st <= S_HALT;
                default: st <= S_HALT;
            endcase
        end
    end
endmodule
